image_loader: RTL

//  Upstream boot stage for the barrel core. Receives a program image over a

---
 rtl/image_loader_pkg.sv | 31 +++
 rtl/loader_tx.sv | 32 +++
 rtl/image_loader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/image_loader_pkg.sv
// Shared constants for the boot loader: one-hot FSM encodings and protocol bytes.
package image_loader_pkg;

    localparam logic [7:0] StIdle   = 8'b0000_0001;
    localparam logic [7:0] StLen0   = 8'b0000_0010;
    localparam logic [7:0] StLen1   = 8'b0000_0100;
    localparam logic [7:0] StData   = 8'b0000_1000;
    localparam logic [7:0] StCsum   = 8'b0001_0000;
    localparam logic [7:0] StResp   = 8'b0010_0000;
    localparam logic [7:0] StRun    = 8'b0100_0000;
    localparam logic [7:0] StExitTx = 8'b1000_0000;

    localparam logic [7:0] SyncByte    = 8'hA5;
    localparam logic [7:0] AckByte     = 8'h06;
    localparam logic [7:0] NakByte     = 8'h15;
    localparam logic [7:0] ExitTagByte = 8'h45;

    // Byte n of the exit code, LSB first.
    function automatic logic [7:0] code_byte(input logic [31:0] code, input logic [2:0] n);
        logic [7:0] b;
        b = code[7:0];
        case (n)
            3'd1:    b = code[15:8];
            3'd2:    b = code[23:16];
            3'd3:    b = code[31:24];
            default: b = code[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/loader_tx.sv
// One-byte outbound holding register; the loader FSM loads it and waits on ready.
module loader_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    logic [7:0] data_q;
    logic       valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            valid_q <= 1'b1;
        end else if (tx_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign ready    = ~valid_q;
    assign tx_data  = data_q;
    assign tx_valid = valid_q;

endmodule

// File: rtl/image_loader.sv
// Boot stage: streams a program image into core RAM, answers ACK/NAK, runs the
// core and reports its exit code before re-holding it in reset.
module image_loader
    import image_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [7:0]  SYNC       = SyncByte,
    parameter logic [7:0]  ACK        = AckByte,
    parameter logic [7:0]  NAK        = NakByte,
    parameter logic [7:0]  EXIT_TAG   = ExitTagByte
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-3:0] ram_addr,
    output logic [31:0]           ram_din,
    output logic [3:0]            ram_bwe,
    output logic                  core_resetn,
    input  logic                  core_exit,
    input  logic [31:0]           core_exitcode
);

    localparam int unsigned Capacity = 2 ** (ADDR_WIDTH - 2);

    logic [7:0]            state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           idx_q, idx_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [31:0]           word_q, word_d;
    logic [7:0]            sum_q, sum_d;
    logic [31:0]           code_q, code_d;
    logic [2:0]            ecnt_q, ecnt_d;
    logic                  ok_q, ok_d;
    logic                  core_resetn_q, core_resetn_d;
    logic                  rx_ready_q, rx_ready_d;
    logic [ADDR_WIDTH-3:0] ram_addr_q, ram_addr_d;
    logic [31:0]           ram_din_q, ram_din_d;
    logic [3:0]            ram_bwe_q, ram_bwe_d;

    logic       rx_fire;
    logic [15:0] len_full;
    logic       tx_load;
    logic [7:0] tx_byte;
    logic       tx_free;

    assign rx_fire  = rx_valid & rx_ready_q;
    assign len_full = {rx_data, len_q[7:0]};

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        bcnt_d        = bcnt_q;
        word_d        = word_q;
        sum_d         = sum_q;
        code_d        = code_q;
        ecnt_d        = ecnt_q;
        ok_d          = ok_q;
        core_resetn_d = core_resetn_q;
        ram_addr_d    = ram_addr_q;
        ram_din_d     = ram_din_q;
        ram_bwe_d     = 4'b0000;
        tx_load       = 1'b0;
        tx_byte       = NAK;

        case (state_q)
            StIdle: begin
                if (rx_fire && rx_data == SYNC) state_d = StLen0;
            end
            StLen0: begin
                if (rx_fire) begin
                    len_d[7:0] = rx_data;
                    state_d    = StLen1;
                end
            end
            StLen1: begin
                if (rx_fire) begin
                    len_d  = len_full;
                    idx_d  = 16'd0;
                    bcnt_d = 2'd0;
                    sum_d  = 8'd0;
                    if ({1'b0, len_full} > 17'(Capacity)) begin
                        tx_load = 1'b1;
                        tx_byte = NAK;
                        ok_d    = 1'b0;
                        state_d = StResp;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (rx_fire) begin
                    word_d = {rx_data, word_q[31:8]};
                    sum_d  = sum_q + rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        ram_din_d  = word_d;
                        ram_addr_d = idx_q[ADDR_WIDTH-3:0];
                        ram_bwe_d  = 4'b1111;
                        idx_d      = idx_q + 16'd1;
                        if (idx_q == len_q - 16'd1) state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (rx_fire) begin
                    tx_load = 1'b1;
                    ok_d    = (rx_data == sum_q);
                    tx_byte = (rx_data == sum_q) ? ACK : NAK;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (tx_free) begin
                    if (ok_q) begin
                        core_resetn_d = 1'b1;
                        state_d       = StRun;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StRun: begin
                if (core_exit) begin
                    code_d        = core_exitcode;
                    core_resetn_d = 1'b0;
                    tx_load       = 1'b1;
                    tx_byte       = EXIT_TAG;
                    ecnt_d        = 3'd0;
                    state_d       = StExitTx;
                end
            end
            StExitTx: begin
                // ecnt counts exit-code bytes already handed to the tx register.
                if (tx_free) begin
                    if (ecnt_q == 3'd4) begin
                        state_d = StIdle;
                    end else begin
                        tx_load = 1'b1;
                        tx_byte = code_byte(code_q, ecnt_q);
                        ecnt_d  = ecnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        rx_ready_d = (state_d == StIdle) || (state_d == StLen0) || (state_d == StLen1) ||
                     (state_d == StData) || (state_d == StCsum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            len_q         <= 16'd0;
            idx_q         <= 16'd0;
            bcnt_q        <= 2'd0;
            word_q        <= 32'd0;
            sum_q         <= 8'd0;
            code_q        <= 32'd0;
            ecnt_q        <= 3'd0;
            ok_q          <= 1'b0;
            core_resetn_q <= 1'b0;
            rx_ready_q    <= 1'b0;
            ram_addr_q    <= '0;
            ram_din_q     <= 32'd0;
            ram_bwe_q     <= 4'b0000;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            bcnt_q        <= bcnt_d;
            word_q        <= word_d;
            sum_q         <= sum_d;
            code_q        <= code_d;
            ecnt_q        <= ecnt_d;
            ok_q          <= ok_d;
            core_resetn_q <= core_resetn_d;
            rx_ready_q    <= rx_ready_d;
            ram_addr_q    <= ram_addr_d;
            ram_din_q     <= ram_din_d;
            ram_bwe_q     <= ram_bwe_d;
        end
    end

    loader_tx u_tx (
        .clk      (clk),
        .reset    (reset),
        .load     (tx_load),
        .load_data(tx_byte),
        .ready    (tx_free),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    assign rx_ready    = rx_ready_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign ram_bwe     = ram_bwe_q;
    assign core_resetn = core_resetn_q;

endmodule
